// File: rtl/mwc_pkg.sv
// Shared types and width helpers for the memory write checker.
package mwc_pkg;

  localparam int MWC_ADDR_W   = 32;
  localparam int MWC_DATA_W   = 32;
  localparam int MWC_N_EXPECT = 4;

  // Index width never collapses to zero, so a single-entry table stays legal.
  function automatic int mwc_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int mwc_cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int MWC_IDX_W = mwc_idx_w(MWC_N_EXPECT);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    PASS    = 3'd2,
    FAIL    = 3'd3,
    TIMEOUT = 3'd4
  } mwc_state_t;

  typedef struct packed {
    logic [MWC_ADDR_W-1:0] addr;
    logic [MWC_DATA_W-1:0] data;
    logic                  is_byte;
  } mwc_entry_t;

endpackage

// File: rtl/mwc_expect_table.sv
// Expected-write register file: one write port, one combinational read port.
module mwc_expect_table
  import mwc_pkg::*;
#(
  parameter int N     = MWC_N_EXPECT,
  parameter int IDX_W = MWC_IDX_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  mwc_entry_t       wr_entry,
  input  logic [IDX_W-1:0] rd_idx,
  output mwc_entry_t       rd_entry
);

  mwc_entry_t mem_r [N];

  // Table storage; reset wins over a concurrent load.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        mem_r[i] <= '0;
      end
    end else if (we && (32'(wr_idx) < N)) begin
      mem_r[wr_idx] <= wr_entry;
    end
  end

  assign rd_entry = mem_r[rd_idx];

endmodule

// File: rtl/mem_write_checker.sv
// Checks that bus writes hit an expected address/data sequence in order,
// reporting pass, fail (with the offending write) or timeout.
module mem_write_checker
  import mwc_pkg::*;
#(
  parameter int ADDR_W         = MWC_ADDR_W,  // must equal MWC_ADDR_W
  parameter int DATA_W         = MWC_DATA_W,  // must equal MWC_DATA_W
  parameter int N_EXPECT       = MWC_N_EXPECT,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter bit STRICT         = 1'b0
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic                              MemWrite,
  input  logic                              ByteMem,
  input  logic [ADDR_W-1:0]                 DataAdr,
  input  logic [DATA_W-1:0]                 WriteData,
  input  logic                              exp_we,
  input  logic [mwc_idx_w(N_EXPECT)-1:0]    exp_idx,
  input  logic [ADDR_W-1:0]                 exp_addr,
  input  logic [DATA_W-1:0]                 exp_data,
  input  logic                              exp_byte,
  output logic                              done,
  output logic                              pass,
  output logic                              fail,
  output logic                              timeout,
  output logic [mwc_cnt_w(N_EXPECT)-1:0]    match_count,
  output logic [ADDR_W-1:0]                 fail_addr,
  output logic [DATA_W-1:0]                 fail_data
);

  localparam int IDX_W = mwc_idx_w(N_EXPECT);
  localparam int CNT_W = mwc_cnt_w(N_EXPECT);
  localparam int TMR_W = mwc_idx_w(TIMEOUT_CYCLES);
  localparam logic [IDX_W-1:0] LAST_PTR = IDX_W'(N_EXPECT - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  mwc_state_t       state_r, state_nxt_s;
  logic [IDX_W-1:0] ptr_r, ptr_nxt_s;
  logic [TMR_W-1:0] tmr_r, tmr_nxt_s;
  logic [CNT_W-1:0] mcnt_nxt_s;
  logic             capture_s;
  logic             tbl_we_s;
  logic             addr_hit_s;
  logic             data_ok_s;
  logic             match_s;
  mwc_entry_t       wr_entry_s;
  mwc_entry_t       entry_s;

  assign tbl_we_s   = exp_we && (state_r == IDLE);
  assign wr_entry_s = '{addr: exp_addr, data: exp_data, is_byte: exp_byte};

  mwc_expect_table #(
    .N     (N_EXPECT),
    .IDX_W (IDX_W)
  ) u_table (
    .clk      (clk),
    .reset    (reset),
    .we       (tbl_we_s),
    .wr_idx   (exp_idx),
    .wr_entry (wr_entry_s),
    .rd_idx   (ptr_r),
    .rd_entry (entry_s)
  );

  // Byte entries compare only the low data byte; word entries compare all bits.
  assign addr_hit_s = (DataAdr == entry_s.addr);
  assign data_ok_s  = entry_s.is_byte ? (WriteData[7:0] == entry_s.data[7:0])
                                      : (WriteData == entry_s.data);
  assign match_s    = addr_hit_s && (ByteMem == entry_s.is_byte) && data_ok_s;

  // Next-state logic; branch order gives PASS over FAIL over TIMEOUT.
  always_comb begin
    state_nxt_s = state_r;
    ptr_nxt_s   = ptr_r;
    tmr_nxt_s   = tmr_r;
    mcnt_nxt_s  = match_count;
    capture_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (MemWrite && match_s) begin
          mcnt_nxt_s = match_count + 1'b1;
          if (ptr_r == LAST_PTR) begin
            state_nxt_s = PASS;
          end else begin
            ptr_nxt_s = ptr_r + 1'b1;
          end
        end else if (MemWrite && (addr_hit_s || STRICT)) begin
          state_nxt_s = FAIL;
          capture_s   = 1'b1;
        end else if (tmr_r == TMR_LAST) begin
          state_nxt_s = TIMEOUT;
        end else begin
          tmr_nxt_s = tmr_r + 1'b1;
        end
      end
      PASS, FAIL, TIMEOUT: begin
        state_nxt_s = state_r;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, counters and status outputs, decoded from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      ptr_r       <= '0;
      tmr_r       <= '0;
      match_count <= '0;
      fail_addr   <= '0;
      fail_data   <= '0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      ptr_r       <= ptr_nxt_s;
      tmr_r       <= tmr_nxt_s;
      match_count <= mcnt_nxt_s;
      if (capture_s) begin
        fail_addr <= DataAdr;
        fail_data <= WriteData;
      end
      done    <= (state_nxt_s == PASS) || (state_nxt_s == FAIL) || (state_nxt_s == TIMEOUT);
      pass    <= (state_nxt_s == PASS);
      fail    <= (state_nxt_s == FAIL);
      timeout <= (state_nxt_s == TIMEOUT);
    end
  end

endmodule
